// File: rtl/tx_filter_sequencer.sv
// tx_filter_sequencer: symbol/phase timing for the 4-phase BPSK polyphase TX FIR.
// Generates the polyphase select and the FIR shift enable, sources a PRBS9
// symbol stream, and runs fixed-length or continuous bursts.
//
// Handshake: i_start is a one-cycle request, accepted only when the sequencer
// is idle and i_enable is high. o_busy stays high from the following cycle
// until the burst ends. o_done pulses for one (enabled) cycle on return to idle.
// A new i_start may be given in the o_done cycle. i_enable low stalls everything.
module tx_filter_sequencer #(
  parameter int          NBAUDS   = 6,
  parameter int          NB_COUNT = 16,
  parameter logic [8:0]  SEED     = 9'h1FF
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [NB_COUNT-1:0] i_nsym,
  output logic                o_data_bit,
  output logic [2:0]          o_counterMux,
  output logic                o_filter_enable,
  output logic                o_out_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic [1:0]          o_dbg_state
);

  localparam int         FW       = $clog2(NBAUDS + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(NBAUDS);
  // An all-zero PRBS would lock up, so a zero seed falls back to all ones.
  localparam logic [8:0] SEED_EFF = (SEED == 9'h000) ? 9'h1FF : SEED;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_TAIL = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            phase_q, phase_d;
  logic [8:0]            prbs_q, prbs_d;
  logic [NB_COUNT-1:0]   sym_q, sym_d;
  logic [NB_COUNT-1:0]   nsym_q, nsym_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic                  stop_pending_q, stop_pending_d;
  logic                  done_q, done_d;

  logic [NB_COUNT-1:0]   sym_inc;
  logic                  last_sym;

  assign sym_inc  = sym_q + NB_COUNT'(1);
  // The load about to happen is symbol number sym_q+1; zero means continuous.
  assign last_sym = (nsym_q != '0) && (sym_inc == nsym_q);

  // Next-state logic: everything holds unless i_enable is high.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    prbs_d         = prbs_q;
    sym_d          = sym_q;
    nsym_d         = nsym_q;
    fill_d         = fill_q;
    stop_pending_d = stop_pending_q;
    done_d         = done_q;
    if (i_enable) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          phase_d        = 2'b01;
          stop_pending_d = 1'b0;
          if (i_start) begin
            state_d = S_RUN;
            nsym_d  = i_nsym;
            sym_d   = '0;
            fill_d  = '0;
            prbs_d  = SEED_EFF;
          end
        end
        S_RUN: begin
          phase_d = phase_q + 2'd1;
          if (i_stop) stop_pending_d = 1'b1;
          // Load edge: the FIR shifts o_data_bit in at the end of this cycle.
          if (phase_q == 2'b01) begin
            prbs_d = {prbs_q[7:0], prbs_q[8] ^ prbs_q[4]};
            sym_d  = sym_inc;
            if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
            if (stop_pending_q || i_stop || last_sym) state_d = S_TAIL;
          end
        end
        S_TAIL: begin
          // Finish phases 10, 11, 00 of the last symbol without loading.
          phase_d = phase_q + 2'd1;
          if (i_stop) stop_pending_d = 1'b1;
          if (phase_q == 2'b00) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = 2'b01;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q        <= S_IDLE;
      phase_q        <= 2'b01;
      prbs_q         <= SEED_EFF;
      sym_q          <= '0;
      nsym_q         <= '0;
      fill_q         <= '0;
      stop_pending_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      prbs_q         <= prbs_d;
      sym_q          <= sym_d;
      nsym_q         <= nsym_d;
      fill_q         <= fill_d;
      stop_pending_q <= stop_pending_d;
      done_q         <= done_d;
    end
  end

  assign o_data_bit      = prbs_q[8];
  assign o_counterMux    = {1'b0, phase_q};
  assign o_busy          = (state_q != S_IDLE);
  assign o_filter_enable = i_enable && (state_q != S_IDLE);
  assign o_out_valid     = i_enable && ((state_q == S_RUN) || (state_q == S_TAIL)) &&
                           (fill_q == FILL_MAX);
  assign o_done          = done_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_tx_filter_sequencer.sv
// Bench for tx_filter_sequencer: directed scenarios plus random stimulus,
// checked every cycle against a burst-level reference model.
module tb_tx_filter_sequencer;

  localparam int NBAUDS = 6;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        i_reset, i_enable, i_start, i_stop;
  logic [15:0] i_nsym;
  logic        o_data_bit, o_filter_enable, o_out_valid, o_busy, o_done;
  logic [2:0]  o_counterMux;
  logic [1:0]  o_dbg_state;

  always #5 clock = ~clock;

  tx_filter_sequencer #(.NBAUDS(NBAUDS), .NB_COUNT(16), .SEED(9'h1FF)) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_nsym         (i_nsym),
    .o_data_bit     (o_data_bit),
    .o_counterMux   (o_counterMux),
    .o_filter_enable(o_filter_enable),
    .o_out_valid    (o_out_valid),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // seq[i] is the symbol bit after i loads from the seed (period 511).
  bit seq [0:510];
  // Burst-level view: m_k = enabled-cycle index within the burst (1 = first RUN
  // cycle), loads finish at k = 4n-3, burst ends after k = 4*m_nend.
  bit m_busy, m_done;
  int m_k, m_nsym, m_stop_k, m_nend, m_idle_idx;

  // directed-test monitors
  int cyc;
  int done_cyc, valid_cnt, valid_first;
  bit prbs_capture;
  logic [11:0] prbs_first12;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_k = 0; m_nsym = 0;
    m_stop_k = 0; m_nend = 0; m_idle_idx = 0;
  endtask

  // ---------------- driver: one cycle ----------------
  task automatic step(input logic rst, input logic en, input logic st,
                      input logic sp, input logic [15:0] ns);
    int         ld, n;
    logic [2:0] e_cm;
    logic       e_fe, e_valid, e_busy, e_bit;
    i_reset = rst; i_enable = en; i_start = st; i_stop = sp; i_nsym = ns;
    #3;
    if (m_busy) begin
      ld      = (m_k + 2) / 4;
      e_cm    = {1'b0, 2'(m_k % 4)};
      e_fe    = en;
      e_busy  = 1'b1;
      e_valid = en && (ld >= NBAUDS);
      e_bit   = seq[ld % 511];
    end else begin
      e_cm    = 3'b001;
      e_fe    = 1'b0;
      e_busy  = 1'b0;
      e_valid = 1'b0;
      e_bit   = seq[m_idle_idx % 511];
    end
    check("data_bit",      32'(o_data_bit),      32'(e_bit));
    check("counterMux",    32'(o_counterMux),    32'(e_cm));
    check("filter_enable", 32'(o_filter_enable), 32'(e_fe));
    check("out_valid",     32'(o_out_valid),     32'(e_valid));
    check("busy",          32'(o_busy),          32'(e_busy));
    check("done",          32'(o_done),          32'(m_done));
    if (prbs_capture && (cyc % 4 == 1) && ((cyc + 3) / 4 <= 12))
      check("prbs_first12", 32'(o_data_bit), 32'(prbs_first12[12 - (cyc + 3) / 4]));
    if (o_done === 1'b1) done_cyc = cyc;
    if (o_out_valid === 1'b1) begin
      if (valid_cnt == 0) valid_first = cyc;
      valid_cnt++;
    end
    @(posedge clock); #1;
    // model update with this cycle's inputs
    if (!rst) begin
      model_reset();
    end else if (en) begin
      if (!m_busy) begin
        m_done = 0;
        if (st) begin
          m_busy = 1; m_k = 1; m_nsym = int'(ns); m_stop_k = 0; m_nend = 0;
        end
      end else begin
        if (sp && m_stop_k == 0) m_stop_k = m_k;
        if ((m_k % 4 == 1) && m_nend == 0) begin
          n = (m_k + 3) / 4;
          if (m_stop_k != 0 || (m_nsym != 0 && n == m_nsym)) m_nend = n;
        end
        if (m_nend != 0 && m_k == 4 * m_nend) begin
          m_busy = 0; m_done = 1; m_idle_idx = m_nend;
        end else begin
          m_k++;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic clear_mon();
    cyc = 0; done_cyc = -1; valid_cnt = 0; valid_first = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] r;
    r = 9'h1FF;
    for (int i = 0; i < 511; i++) begin
      seq[i] = r[8];
      r = {r[7:0], r[8] ^ r[4]};
    end
    prbs_first12 = 12'b1111_1111_1000;
    prbs_capture = 0;
    model_reset();
    i_reset = 0; i_enable = 1; i_start = 0; i_stop = 0; i_nsym = 0;
    clear_mon();
    @(posedge clock); #1;
    // reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    idle(2);

    // reset mid-RUN at cycle 7
    clear_mon();
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    for (int i = 1; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    check("rst_busy",  32'(o_busy), 32'd0);
    check("rst_cmux",  32'(o_counterMux), 32'd1);
    check("rst_fen",   32'(o_filter_enable), 32'd0);
    idle(2);

    // short burst, nsym = 3
    clear_mon();
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd3);
    idle(16);
    check("short_done_cyc", 32'(done_cyc), 32'd13);
    check("short_valid_cnt", 32'(valid_cnt), 32'd0);

    // warm-up, nsym = 8
    clear_mon();
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd8);
    idle(36);
    check("warm_valid_first", 32'(valid_first), 32'd22);
    check("warm_valid_cnt",   32'(valid_cnt),   32'd11);
    check("warm_done_cyc",    32'(done_cyc),    32'd33);

    // PRBS: continuous, 1022 symbols, then stop
    clear_mon();
    prbs_capture = 1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    idle(4 * 1022);
    prbs_capture = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'd0);
    idle(10);

    // stop pulse at cycle 6
    clear_mon();
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    for (int c = 1; c < 18; c++) step(1'b1, 1'b1, 1'b0, (c == 6), 16'd0);
    check("stop_done_cyc", 32'(done_cyc), 32'd13);

    // same with a stall in cycles 3-4
    clear_mon();
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    for (int c = 1; c < 20; c++)
      step(1'b1, !(c == 3 || c == 4), 1'b0, (c == 8), 16'd0);
    check("stall_done_cyc", 32'(done_cyc), 32'd15);

    // ignored inputs: start while busy, stop while idle
    clear_mon();
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd2);
    for (int c = 1; c < 12; c++) step(1'b1, 1'b1, (c == 3), 1'b0, 16'd5);
    check("ign_start_done_cyc", 32'(done_cyc), 32'd9);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'd0);
    clear_mon();
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd1);
    idle(8);
    check("ign_stop_done_cyc", 32'(done_cyc), 32'd5);

    // random stimulus
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0),
           16'($urandom_range(0, 12)));
    end
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
